// File: rtl/serial_frame_receiver_if.sv
// Purpose : bundles the serial input and parallel result signals of serial_frame_receiver.
// Latency : none (wiring only).
// Backpressure: none; the consumer must take each valid pulse as it occurs.
// Signals: bit_en/din (serial side, driven by master), data_out/valid/frame_err/
//          parity_err/busy (result side, driven by slave = the receiver).
interface serial_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              din;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              parity_err;
    logic              busy;

    // Serial source / observer side.
    modport master (
        output bit_en, din,
        input  data_out, valid, frame_err, parity_err, busy
    );

    // Receiver side.
    modport slave (
        input  bit_en, din,
        output data_out, valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Purpose : single-wire serial frame receiver (start, DATA_W bits LSB-first, [parity], stop).
// Latency : valid/data_out/frame_err/parity_err appear the cycle after the stop-bit sample.
// Backpressure: none; results are 1-cycle pulses, data_out holds the last good word.
//
// Ports: clk, reset (async active-high); rx (slave modport) carries bit_en, din in and
//        data_out, valid, frame_err, parity_err, busy out. All outputs are registered.
// Optional feature macro: PARITY_CHECK_EN adds an even-parity bit after the data bits.
module serial_frame_receiver #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_frame_receiver_if.slave rx
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              busy_q, busy_d;
`ifdef PARITY_CHECK_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d        = par_q;
`endif
        if (rx.bit_en) begin
            case (state_q)
                IDLE: begin
                    // A single low sample is accepted as a start bit.
                    if (!rx.din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
                    // Written as shifts so DATA_W=1 needs no special case.
                    shreg_d = (shreg_q >> 1) | (DATA_W'(rx.din) << (DATA_W - 1));
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    par_d   = rx.din;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (rx.din) begin
                        data_out_d = shreg_q;
                        valid_d    = 1'b1;
`ifdef PARITY_CHECK_EN
                        // Even parity: data bits XOR parity bit must be zero.
                        parity_err_d = (^shreg_q) ^ par_q;
`endif
                    end else begin
                        // Bad stop bit: word dropped, parity result suppressed.
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
`ifdef PARITY_CHECK_EN
            par_q        <= par_d;
`endif
        end
    end

    assign rx.data_out   = data_out_q;
    assign rx.valid      = valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.parity_err = parity_err_q;
    assign rx.busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Purpose : directed, table-driven check of serial_frame_receiver (DATA_W=8).
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_frame_receiver;

    logic clk;
    logic reset;

    serial_frame_receiver_if #(.DATA_W(8)) bus ();

    serial_frame_receiver #(.DATA_W(8), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Negedge monitor: records delivered words and counts error pulses.
    logic [7:0] vq[$];
    int ferr_cnt = 0;
    int perr_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.valid === 1'b1) vq.push_back(bus.data_out);
            if (bus.frame_err === 1'b1) ferr_cnt++;
            if (bus.parity_err === 1'b1) perr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds a bit for 'period' cycles, strobing bit_en on the last one.
    task automatic drive_bit(input logic b, input int period);
        for (int i = 0; i < period; i++) begin
            bus.din    = b;
            bus.bit_en = (i == period - 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the stop-bit sampling edge, with bit_en still high.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int period,
                              input logic par_bad);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(data[i], period);
`ifdef PARITY_CHECK_EN
        drive_bit((^data) ^ par_bad, period);
`endif
        drive_bit(stop, period);
    endtask

    task automatic go_idle();
        bus.bit_en = 1'b0;
        bus.din    = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         period;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'hA5, 1'b1, 3, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 1, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{8'h5A, 1'b0, 2, 1'b0, 1'b1, 8'hA5};
        vecs[4] = '{8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 4, 1'b1, 1'b0, 8'hFF};

        reset      = 1'b1;
        bus.bit_en = 1'b0;
        bus.din    = 1'b1;
        #12;
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Idle line, and a low line without bit_en, must not start a frame.
        bus.din = 1'b1; bus.bit_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.din = 1'b0; bus.bit_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start_busy", 32'(bus.busy), 32'h0);
        go_idle();

        for (int v = 0; v < 6; v++) begin
            vq.delete();
            ferr_cnt = 0;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].period, 1'b0);
            go_idle();
            @(negedge clk);
            check($sformatf("v%0d_valid_latency", v), 32'(bus.valid), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_ferr_latency", v), 32'(bus.frame_err), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_perr", v), 32'(bus.parity_err), 32'h0);
            check($sformatf("v%0d_busy_after", v), 32'(bus.busy), 32'h0);
            @(negedge clk);
            check($sformatf("v%0d_valid_cleared", v), 32'(bus.valid), 32'h0);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_valid_pulses", v), 32'(vq.size()), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_ferr_pulses", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_data_out", v), 32'(bus.data_out), 32'(vecs[v].exp_dout));
            @(posedge clk);
            #1;
        end

        // Async reset in the middle of a 0xFF frame (after 4 data bits).
        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1);
        go_idle();
        check("midframe_busy", 32'(bus.busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_data_out", 32'(bus.data_out), 32'h00);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        check("async_rst_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        vq.delete();
        send_frame(8'h12, 1'b1, 1, 1'b0);
        go_idle();
        repeat (3) @(negedge clk);
        check("post_rst_pulses", 32'(vq.size()), 32'h1);
        check("post_rst_data_out", 32'(bus.data_out), 32'h12);
        @(posedge clk);
        #1;

        // Back-to-back frames: start bit sampled on the edge after the stop sample.
        vq.delete();
        send_frame(8'h01, 1'b1, 1, 1'b0);
        send_frame(8'hFE, 1'b1, 1, 1'b0);
        go_idle();
        repeat (3) @(negedge clk);
        check("b2b_pulses", 32'(vq.size()), 32'h2);
        check("b2b_word0", 32'(vq.size() > 0 ? vq[0] : 8'hxx), 32'h01);
        check("b2b_word1", 32'(vq.size() > 1 ? vq[1] : 8'hxx), 32'hFE);
        check("b2b_data_out", 32'(bus.data_out), 32'hFE);
        @(posedge clk);
        #1;

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 1, 1'b0);
        go_idle();
        @(negedge clk);
        check("par_ok_valid", 32'(bus.valid), 32'h1);
        check("par_ok_perr", 32'(bus.parity_err), 32'h0);
        @(posedge clk);
        #1;
        send_frame(8'h07, 1'b1, 1, 1'b1);
        go_idle();
        @(negedge clk);
        check("par_bad_valid", 32'(bus.valid), 32'h1);
        check("par_bad_perr", 32'(bus.parity_err), 32'h1);
        check("par_bad_data_out", 32'(bus.data_out), 32'h07);
        repeat (2) @(negedge clk);
        check("perr_pulse_total", 32'(perr_cnt), 32'h1);
`else
        check("perr_pulse_total", 32'(perr_cnt), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
